sumador_serial: RTL and testbench
=================================

SUMADOR_SERIAL -- requirements
Module: sumador_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op, input, 1 bit: 0 = add (A+B+cin), 1 = subtract (A-B-cin).
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled only when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in for add, or borrow-in for subtract; sampled with the operands.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 The block SHALL have port s, output, WIDTH bits: the result.
REQ-011 The block SHALL have port cout, output, 1 bit: raw carry out of the MSB; for subtract, 1 = no borrow.
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The block SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL be accepted: a, b, op and cin latched; FSM goes to RUN; bit counter cleared.
REQ-015 On acceptance, the block SHALL load the internal B register with b for add or ~b for sub, and the carry flop with cin for add or ~cin for sub.
REQ-016 In RUN, the block SHALL process one bit per cycle, LSB first, via the full-adder cell:
- the sum bit is shifted into the result register;
- the carry flop is updated;
- the operand registers shift right.
REQ-017 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE; total latency from the accepting edge to done=1 is WIDTH+1 cycles.
REQ-018 On the DONE-entry edge, the block SHALL capture cout as the final carry flop value.
REQ-019 On the same edge, ovf SHALL be captured as carry-into-MSB XOR carry-out-of-MSB.
REQ-020 done SHALL be 1 only in the DONE state, which lasts one cycle; the FSM then returns to IDLE unless start=1 (back-to-back, REQ-014).
REQ-021 busy SHALL be 1 exactly in RUN.
REQ-022 start while busy=1 SHALL be ignored, with no effect on state or registers.
REQ-023 s, cout and ovf SHALL hold their last completed values through IDLE and through a subsequent RUN; they update only on DONE entry.
REQ-024 s SHALL NOT show partial results: the shift register is internal, and s is a separate output register.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH; the block SHALL NOT saturate.

Reset
REQ-026 When rst=1, the block SHALL asynchronously force:
- FSM to IDLE;
- busy=0, done=0;
- s=0, cout=0, ovf=0;
- counter, carry and operand registers to 0.
REQ-027 Reset mid-operation SHALL abort it with no done pulse, and the partial result SHALL be discarded.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-029 A shared definitions file SHALL hold:
- the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
- the opcode constants OP_ADD=1'b0 and OP_SUB=1'b1.
REQ-030 The 1-bit full adder SHALL be a sub-module named suma_bit (ports s, cout, a, b, cin), instantiated once.
REQ-031 The counter width SHALL be $clog2(WIDTH+1) bits.

Verification (WIDTH=8)
REQ-032 Add 0x3C + 0x0F, cin=0 -> done 9 cycles after accept; s=0x4B, cout=0, ovf=0; busy high for exactly 8 cycles.
REQ-033 Add 0x7F + 0x01 -> s=0x80, cout=0, ovf=1; add 0xFF + 0x01 -> s=0x00, cout=1, ovf=0.
REQ-034 Sub 0x05 - 0x07, cin=0 -> s=0xFE, cout=0, ovf=0; sub 0x80 - 0x01 -> s=0x7F, cout=1, ovf=1.
REQ-035 Start pulsed mid-RUN with different operands -> ignored; the original result is delivered on schedule.
REQ-036 rst asserted at RUN cycle 4 -> immediately busy=0 and s=0; no done; the next op 0x10 + 0x20 -> s=0x30.
REQ-037 start held high through the DONE cycle with new operands -> the second operation begins with no IDLE cycle; two done pulses are 9 cycles apart.

Source files
------------

// File: rtl/sumador_serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encodings and opcodes.
// No logic; constants only.
// No flow control.
package sumador_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/suma_bit.sv
// One-bit full adder cell used by the serial datapath.
// Combinational, zero latency.
// No flow control.
module suma_bit (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial add/subtract, LSB first, one full-adder cell shared across all bits.
// Latency: WIDTH RUN cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is only honoured in IDLE/DONE; requests while busy are dropped.
module sumador_serial
    import sumador_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] sh_q;
    logic             c_q;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sh_next;

    suma_bit u_suma_bit (
        .s    (fa_s),
        .cout (fa_c),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q)
    );

    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign sh_next = {fa_s, sh_q};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Subtraction is A + ~B + ~borrow, so the inversion happens once at load time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sh_q  <= '0;
            c_q   <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            a_q   <= a;
            b_q   <= (op == OP_SUB) ? ~b : b;
            c_q   <= (op == OP_SUB) ? ~cin : cin;
            sh_q  <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + CW'(1);
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            c_q   <= fa_c;
            sh_q  <= sh_next[WIDTH-1:1];
            if (last) begin
                // c_q still holds the carry into the MSB on this final bit.
                s    <= sh_next;
                cout <= fa_c;
                ovf  <= c_q ^ fa_c;
            end
        end
    end

endmodule

// File: tb/tb_sumador_serial.sv
// Directed bench for sumador_serial (WIDTH=8) with hand-computed expected results.
module tb_sumador_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sumador_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency counts the accepting edge as 1; returns sampled #1 after the done edge.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input int glitch_at,
                          output int lat, output int nbusy, output logic s_moved);
        logic [W-1:0] s_prev;
        @(negedge clk);
        op = o; a = x; b = y; cin = ci; start = 1'b1;
        s_prev = s;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 1;
        nbusy   = 0;
        s_moved = 1'b0;
        while (!done && lat < 4 * W) begin
            if (busy) nbusy++;
            if (s !== s_prev) s_moved = 1'b1;
            if (lat == glitch_at) begin
                start = 1'b1; op = ~o; a = ~x; b = 8'h5A; cin = ~ci;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_case(input string tag, input logic o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic ci, input int glitch_at,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        int   lat;
        int   nbusy;
        logic moved;
        run_op(o, x, y, ci, glitch_at, lat, nbusy, moved);
        chk({tag, "_lat"},  lat,   W + 1);
        chk({tag, "_busy"}, nbusy, W);
        chk({tag, "_hold"}, moved, 1'b0);
        chk({tag, "_s"},    s,     es);
        chk({tag, "_cout"}, cout,  ec);
        chk({tag, "_ovf"},  ovf,   eo);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done, 1'b0);
        chk({tag, "_idle"},  busy, 1'b0);
        chk({tag, "_keep"},  s,    es);
    endtask

    initial begin
        int   lat;
        logic seen;

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_s",    s,    8'h00);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf",  ovf,  1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_case("add_3c0f",  1'b0, 8'h3C, 8'h0F, 1'b0, -1, 8'h4B, 1'b0, 1'b0);
        do_case("add_7f01",  1'b0, 8'h7F, 8'h01, 1'b0, -1, 8'h80, 1'b0, 1'b1);
        do_case("add_ff01",  1'b0, 8'hFF, 8'h01, 1'b0, -1, 8'h00, 1'b1, 1'b0);
        do_case("add_cin",   1'b0, 8'hFF, 8'h00, 1'b1, -1, 8'h00, 1'b1, 1'b0);
        do_case("sub_0507",  1'b1, 8'h05, 8'h07, 1'b0, -1, 8'hFE, 1'b0, 1'b0);
        do_case("glitch",    1'b0, 8'h3C, 8'h0F, 1'b0,  4, 8'h4B, 1'b0, 1'b0);
        do_case("sub_bin",   1'b1, 8'h10, 8'h01, 1'b1, -1, 8'h0E, 1'b1, 1'b0);
        do_case("sub_8001",  1'b1, 8'h80, 8'h01, 1'b0, -1, 8'h7F, 1'b1, 1'b1);

        // Abort in RUN cycle 4: outputs clear asynchronously, no done follows.
        @(negedge clk);
        op = 1'b0; a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_s",    s,    8'h00);
        chk("abort_cout", cout, 1'b0);
        chk("abort_ovf",  ovf,  1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort_nodone", seen, 1'b0);
        do_case("post_rst", 1'b0, 8'h10, 8'h20, 1'b0, -1, 8'h30, 1'b0, 1'b0);

        // start held through DONE: second op begins with no IDLE cycle.
        @(negedge clk);
        op = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        op = 1'b1; a = 8'h50; b = 8'h20; cin = 1'b1;
        lat = 1;
        while (!done && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b1_lat",  lat,  W + 1);
        chk("b2b1_s",    s,    8'h46);
        chk("b2b1_cout", cout, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_done", done, 1'b0);
        lat = 1;
        while (!done && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_gap",   lat,  W + 1);
        chk("b2b2_s",    s,    8'h2F);
        chk("b2b2_cout", cout, 1'b1);
        chk("b2b2_ovf",  ovf,  1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
